serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/fulladder.sv | 13 +
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: state encoding and default width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } serial_add_state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder, sequenced bit-serially by serial_add_ctrl.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller built around one full adder, LSB first.
// Subtraction (a - b) is available only when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

`ifdef SERIAL_ADD_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serial_add_state_e state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic              fa_s, fa_co;

    // b is inverted on its way into the adder so the operand register keeps the raw value
    fulladder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0] ^ sub_q),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub & SUB_EN;
                    carry_d = sub & SUB_EN;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB at this point
                    cout_d  = fa_co;
                    ovf_d   = fa_co ^ carry_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized operations
// against an arithmetic reference model. Honours SERIAL_ADD_SUB_EN like the design.
module tb_serial_add_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        logic         cin;
        logic [W-1:0] yy;
        longint       u;
        int           sx, sy, r;
        logic         v;
        cin = SUB_EN && s;
        yy  = cin ? ~y : y;
        u   = longint'(x) + longint'(yy) + longint'(cin);
        sx  = int'(x);
        sy  = int'(yy);
        if (x[W-1])  sx -= (1 << W);
        if (yy[W-1]) sy -= (1 << W);
        r = sx + sy + int'(cin);
        v = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        return {v, u[W], u[W-1:0]};
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check({tag, "/idle_timeout"}, 32'(busy), 32'd0);
    endtask

    // One operation; inject_at > 0 raises start (with a = 0x11) for that edge after acceptance.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input int inject_at);
        logic [W+1:0] exp;
        int busy_cnt, done_cnt, done_edge;
        exp = model(ta, tb_v, ts);
        wait_idle(tag);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        busy_cnt  = busy ? 1 : 0;
        done_cnt  = 0;
        done_edge = -1;
        for (int e = 1; e <= W + 3; e++) begin
            start = (e == inject_at);
            if (e == inject_at) a = W'(8'h11);
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
                check({tag, "/sum"}, 32'(sum), 32'(exp[W-1:0]));
                check({tag, "/cout"}, 32'(cout), 32'(exp[W]));
                check({tag, "/ovf"}, 32'(ovf), 32'(exp[W+1]));
            end
        end
        start = 1'b0;
        check({tag, "/done_edge"}, 32'(done_edge), 32'(W));
        check({tag, "/done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
        check({tag, "/idle_after"}, 32'(busy), 32'd0);
        check({tag, "/sum_held"}, 32'(sum), 32'(exp[W-1:0]));
        check({tag, "/cout_held"}, 32'(cout), 32'(exp[W]));
    endtask

    initial begin
        logic [W+1:0] exp;
        int prev_done, n_done, idle_between, done_seen;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #1;
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/done", 32'(done), 32'd0);
        check("reset/sum", 32'(sum), 32'd0);
        check("reset/cout_ovf", 32'({cout, ovf}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_5a_3c", W'(8'h5A), W'(8'h3C), 1'b0, 0);
        do_op("add_ff_01", W'(8'hFF), W'(8'h01), 1'b0, 0);
        do_op("restart_ignored", W'(8'h5A), W'(8'h3C), 1'b0, 3);
        do_op("start_in_done", W'(8'h7F), W'(8'h01), 1'b0, W + 1);
        do_op("sub_10_20", W'(8'h10), W'(8'h20), 1'b1, 0);

        // Abort mid-RUN: outputs clear asynchronously and no done follows
        wait_idle("abort");
        @(negedge clk);
        a = W'(8'hC3); b = W'(8'h5A); sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort/sum", 32'(sum), 32'd0);
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/flags", 32'({done, cout, ovf}), 32'd0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort/no_done", 32'(done_seen), 32'd0);
        do_op("after_abort", W'(8'h01), W'(8'h02), 1'b0, 0);

        // start held high: back-to-back operations with one IDLE cycle between them
        wait_idle("b2b");
        exp = model(W'(8'h21), W'(8'h43), 1'b0);
        @(negedge clk);
        a = W'(8'h21); b = W'(8'h43); sub = 1'b0; start = 1'b1;
        prev_done = -1; n_done = 0; idle_between = 0;
        for (int e = 0; e < 4 * (W + 2) && n_done < 3; e++) begin
            @(posedge clk);
            #1;
            if (!busy && n_done >= 1) idle_between++;
            if (done) begin
                check("b2b/sum", 32'(sum), 32'(exp[W-1:0]));
                if (prev_done >= 0) check("b2b/period", 32'(e - prev_done), 32'(W + 2));
                prev_done = e;
                n_done++;
            end
        end
        start = 1'b0;
        check("b2b/ops", 32'(n_done), 32'd3);
        check("b2b/idle_gaps", 32'(idle_between), 32'd2);

        for (int i = 0; i < 24; i++) begin
            int inj;
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0;
            do_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom), inj);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
